// File: rtl/imm_encoder_pkg.sv
// Shared types, opcodes and immediate range bounds for the immediate encoder.
package imm_encoder_pkg;

  typedef enum logic [2:0] {
    TYPE_I  = 3'd0,
    TYPE_S  = 3'd1,
    TYPE_B  = 3'd2,
    TYPE_U  = 3'd3,
    TYPE_J  = 3'd4,
    TYPE_LI = 3'd5
  } imm_type_e;

  typedef enum logic [1:0] {
    EMPTY,
    FULL,
    FULL_PEND
  } enc_state_e;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

  localparam int IS_MIN = -2048;
  localparam int IS_MAX = 2047;
  localparam int B_MIN  = -4096;
  localparam int B_MAX  = 4094;
  localparam int J_MIN  = -(1 << 20);
  localparam int J_MAX  = (1 << 20) - 2;

  function automatic logic [31:0] enc_lui(input logic [4:0] rd, input logic [19:0] hi);
    return {hi, rd, OPC_LUI};
  endfunction

  function automatic logic [31:0] enc_addi(input logic [4:0] rd, input logic [4:0] rs1,
                                           input logic [11:0] imm);
    return {imm, rs1, 3'b000, rd, OPC_OP_IMM};
  endfunction

endpackage

// File: rtl/imm_encoder_if.sv
// Request/response handshake bundle between an instruction producer and the encoder.
interface imm_encoder_if #(
  parameter int unsigned XLEN = 32
) ();
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] in_imm;
  logic [2:0]      in_type;
  logic [31:0]     in_template;
  logic            out_valid;
  logic            out_ready;
  logic [31:0]     out_instr;
  logic            out_err;

  modport master (
    output in_valid, in_imm, in_type, in_template, out_ready,
    input  in_ready, out_valid, out_instr, out_err
  );

  modport slave (
    input  in_valid, in_imm, in_type, in_template, out_ready,
    output in_ready, out_valid, out_instr, out_err
  );
endinterface

// File: rtl/imm_encoder_scatter.sv
// Combinational scatter of an immediate into its instruction fields, with range check.
module imm_encoder_scatter
  import imm_encoder_pkg::*;
(
  input  logic [31:0] imm,
  input  imm_type_e   imm_type,
  output logic [31:0] field_bits,
  output logic [31:0] field_mask,
  output logic        err
);

  logic signed [31:0] simm;
  assign simm = imm;

  always_comb begin
    field_bits = '0;
    field_mask = '0;
    err        = 1'b0;
    case (imm_type)
      TYPE_I: begin
        field_mask = 32'hFFF0_0000;
        field_bits = {imm[11:0], 20'b0};
        err        = (simm < IS_MIN) || (simm > IS_MAX);
      end
      TYPE_S: begin
        field_mask = 32'hFE00_0F80;
        field_bits = {imm[11:5], 13'b0, imm[4:0], 7'b0};
        err        = (simm < IS_MIN) || (simm > IS_MAX);
      end
      TYPE_B: begin
        field_mask = 32'hFE00_0F80;
        field_bits = {imm[12], imm[10:5], 13'b0, imm[4:1], imm[11], 7'b0};
        err        = (simm < B_MIN) || (simm > B_MAX) || imm[0];
      end
      TYPE_U: begin
        field_mask = 32'hFFFF_F000;
        field_bits = {imm[31:12], 12'b0};
        err        = |imm[11:0];
      end
      TYPE_J: begin
        field_mask = 32'hFFFF_F000;
        field_bits = {imm[20], imm[10:1], imm[11], imm[19:12], 12'b0};
        err        = (simm < J_MIN) || (simm > J_MAX) || imm[0];
      end
      // Undefined codes leave the template untouched and flag an error.
      default: err = 1'b1;
    endcase
  end

endmodule

// File: rtl/imm_encoder.sv
// Immediate encoder: builds instruction words from template + immediate, expanding LI
// into LUI/ADDI, behind a registered valid/ready output stage.
module imm_encoder
  import imm_encoder_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input logic          clk,
  input logic          rst_n,
  imm_encoder_if.slave bus
);

  if (XLEN != 32) begin : g_xlen_check
    $error("imm_encoder: only XLEN=32 is supported");
  end

  imm_type_e   req_type;
  logic [31:0] field_bits;
  logic [31:0] field_mask;
  logic        scatter_err;

  assign req_type = imm_type_e'(bus.in_type);

  imm_encoder_scatter u_scatter (
    .imm        (bus.in_imm),
    .imm_type   (req_type),
    .field_bits (field_bits),
    .field_mask (field_mask),
    .err        (scatter_err)
  );

  // hi = (imm + 0x800) >> 12 reduces to a carry from imm[11]; lo is simply imm[11:0].
  logic [4:0]  li_rd;
  logic [19:0] li_hi;
  logic        li_small;

  assign li_rd    = bus.in_template[11:7];
  assign li_hi    = bus.in_imm[31:12] + {19'b0, bus.in_imm[11]};
  assign li_small = ($signed(bus.in_imm) >= IS_MIN) && ($signed(bus.in_imm) <= IS_MAX);

  logic [31:0] enc_first;
  logic [31:0] enc_second;
  logic        enc_err;
  logic        enc_two;

  always_comb begin
    enc_first  = (bus.in_template & ~field_mask) | field_bits;
    enc_second = '0;
    enc_err    = scatter_err;
    enc_two    = 1'b0;
    if (req_type == TYPE_LI) begin
      enc_err = 1'b0;
      if (li_small) begin
        enc_first = enc_addi(li_rd, 5'd0, bus.in_imm[11:0]);
      end else if (bus.in_imm[11:0] == 12'd0) begin
        enc_first = enc_lui(li_rd, li_hi);
      end else begin
        enc_first  = enc_lui(li_rd, li_hi);
        enc_second = enc_addi(li_rd, li_rd, bus.in_imm[11:0]);
        enc_two    = 1'b1;
      end
    end
  end

  enc_state_e  state_q, state_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pend_q, pend_d;
  logic        err_q, err_d;
  logic        accept;

  assign bus.in_ready  = (state_q == EMPTY) || ((state_q == FULL) && bus.out_ready);
  assign accept        = bus.in_valid && bus.in_ready;
  assign bus.out_valid = (state_q != EMPTY);
  assign bus.out_instr = instr_q;
  assign bus.out_err   = err_q;

  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    err_d   = err_q;
    pend_d  = pend_q;
    case (state_q)
      EMPTY, FULL: begin
        if (accept) begin
          instr_d = enc_first;
          err_d   = enc_err;
          pend_d  = enc_second;
          state_d = enc_two ? FULL_PEND : FULL;
        end else if ((state_q == FULL) && bus.out_ready) begin
          state_d = EMPTY;
        end
      end
      FULL_PEND: begin
        if (bus.out_ready) begin
          instr_d = pend_q;
          err_d   = 1'b0;
          state_d = FULL;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      instr_q <= '0;
      err_q   <= 1'b0;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      err_q   <= err_d;
      pend_q  <= pend_d;
    end
  end

endmodule

// File: tb/tb_imm_encoder.sv
// Directed self-checking bench for imm_encoder.
module tb_imm_encoder;
  import imm_encoder_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  imm_encoder_if #(.XLEN(32)) bus();

  imm_encoder #(.XLEN(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  t;
    logic [31:0] imm;
    logic [31:0] tmpl;
    logic [31:0] exp;
    logic        err;
  } enc_vec_t;

  enc_vec_t enc_vecs[15] = '{
    '{3'd0, 32'hFFFF_FFFF, 32'h0000_0093, 32'hFFF0_0093, 1'b0},
    '{3'd0, 32'h0000_0800, 32'h0000_0093, 32'h8000_0093, 1'b1},
    '{3'd1, 32'hFFFF_F800, 32'h0000_2023, 32'h8000_2023, 1'b0},
    '{3'd1, 32'h0000_0015, 32'hFFFF_FFFF, 32'h01FF_FAFF, 1'b0},
    '{3'd2, 32'h0000_0008, 32'h0000_0063, 32'h0000_0463, 1'b0},
    '{3'd2, 32'h0000_0003, 32'h0000_0063, 32'h0000_0163, 1'b1},
    '{3'd2, 32'h0000_0FFE, 32'h0000_0063, 32'h7E00_0FE3, 1'b0},
    '{3'd2, 32'h0000_1000, 32'h0000_0063, 32'h8000_0063, 1'b1},
    '{3'd2, 32'hFFFF_F000, 32'h0000_0063, 32'h8000_0063, 1'b0},
    '{3'd4, 32'h0000_0800, 32'h0000_006F, 32'h0010_006F, 1'b0},
    '{3'd4, 32'h000F_FFFE, 32'h0000_006F, 32'h7FFF_F06F, 1'b0},
    '{3'd4, 32'h0010_0000, 32'h0000_006F, 32'h8000_006F, 1'b1},
    '{3'd3, 32'h1234_5001, 32'h0000_0037, 32'h1234_5037, 1'b1},
    '{3'd3, 32'hABCD_E000, 32'h0000_0FB7, 32'hABCD_EFB7, 1'b0},
    '{3'd7, 32'h0000_0123, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b1}
  };

  typedef struct {
    logic [31:0] imm;
    logic [4:0]  rd;
    int          beats;
    logic [31:0] beat0;
    logic [31:0] beat1;
  } li_vec_t;

  li_vec_t li_vecs[6] = '{
    '{32'h1234_5678, 5'd5, 2, 32'h1234_52B7, 32'h6782_8293},
    '{32'h0000_0FFF, 5'd1, 2, 32'h0000_10B7, 32'hFFF0_8093},
    '{32'h0000_1000, 5'd1, 1, 32'h0000_10B7, 32'h0000_0000},
    '{32'hFFFF_FFFB, 5'd1, 1, 32'hFFB0_0093, 32'h0000_0000},
    '{32'h0000_07FF, 5'd2, 1, 32'h7FF0_0113, 32'h0000_0000},
    '{32'h0000_0800, 5'd2, 2, 32'h0000_1137, 32'h8001_0113}
  };

  task automatic drive_req(input logic [2:0] t, input logic [31:0] imm, input logic [31:0] tmpl);
    bus.in_valid    = 1'b1;
    bus.in_type     = t;
    bus.in_imm      = imm;
    bus.in_template = tmpl;
  endtask

  task automatic settle_empty();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    bus.in_valid    = 1'b0;
    bus.out_ready   = 1'b0;
    bus.in_type     = '0;
    bus.in_imm      = '0;
    bus.in_template = '0;
    rst_n           = 1'b0;
    repeat (2) @(negedge clk);
    n_tests++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", bus.out_valid); end
    n_tests++; if (bus.out_instr !== 32'h0) begin n_fail++; $display("FAIL reset_instr: got %h want 00000000", bus.out_instr); end
    n_tests++; if (bus.out_err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", bus.out_err); end
    rst_n = 1'b1;
    @(negedge clk);
    n_tests++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
    n_tests++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid_after: got %b want 0", bus.out_valid); end
  endtask

  task automatic test_encode();
    settle_empty();
    foreach (enc_vecs[i]) begin
      drive_req(enc_vecs[i].t, enc_vecs[i].imm, enc_vecs[i].tmpl);
      @(posedge clk);
      @(negedge clk);
      bus.in_valid = 1'b0;
      n_tests++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL enc_valid[%0d]: got %b want 1", i, bus.out_valid); end
      n_tests++; if (bus.out_instr !== enc_vecs[i].exp) begin n_fail++; $display("FAIL enc_instr[%0d]: got %h want %h", i, bus.out_instr, enc_vecs[i].exp); end
      n_tests++; if (bus.out_err !== enc_vecs[i].err) begin n_fail++; $display("FAIL enc_err[%0d]: got %b want %b", i, bus.out_err, enc_vecs[i].err); end
    end
  endtask

  task automatic test_li();
    logic [31:0] tmpl;
    logic        exp_ready;
    settle_empty();
    foreach (li_vecs[i]) begin
      tmpl = 32'hA5A5_A07F | ({27'b0, li_vecs[i].rd} << 7);
      drive_req(TYPE_LI, li_vecs[i].imm, tmpl);
      @(posedge clk);
      @(negedge clk);
      bus.in_valid = 1'b0;
      exp_ready = (li_vecs[i].beats == 1);
      n_tests++; if (bus.out_instr !== li_vecs[i].beat0) begin n_fail++; $display("FAIL li_beat0[%0d]: got %h want %h", i, bus.out_instr, li_vecs[i].beat0); end
      n_tests++; if (bus.out_err !== 1'b0) begin n_fail++; $display("FAIL li_err0[%0d]: got %b want 0", i, bus.out_err); end
      n_tests++; if (bus.in_ready !== exp_ready) begin n_fail++; $display("FAIL li_in_ready[%0d]: got %b want %b", i, bus.in_ready, exp_ready); end
      if (li_vecs[i].beats == 2) begin
        @(posedge clk);
        @(negedge clk);
        n_tests++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL li_valid1[%0d]: got %b want 1", i, bus.out_valid); end
        n_tests++; if (bus.out_instr !== li_vecs[i].beat1) begin n_fail++; $display("FAIL li_beat1[%0d]: got %h want %h", i, bus.out_instr, li_vecs[i].beat1); end
        n_tests++; if (bus.out_err !== 1'b0) begin n_fail++; $display("FAIL li_err1[%0d]: got %b want 0", i, bus.out_err); end
      end
    end
  endtask

  task automatic test_backpressure();
    settle_empty();
    bus.out_ready = 1'b0;
    drive_req(TYPE_I, 32'd100, 32'h0000_0013);
    @(posedge clk);
    @(negedge clk);
    // Changed inputs while stalled must be ignored.
    drive_req(TYPE_S, 32'd5, 32'hFFFF_FFFF);
    for (int k = 0; k < 3; k++) begin
      n_tests++; if (bus.out_instr !== 32'h0640_0013) begin n_fail++; $display("FAIL bp_instr[%0d]: got %h want 06400013", k, bus.out_instr); end
      n_tests++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready[%0d]: got %b want 0", k, bus.in_ready); end
      n_tests++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid[%0d]: got %b want 1", k, bus.out_valid); end
      @(negedge clk);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    n_tests++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drained: got %b want 0", bus.out_valid); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp;
    settle_empty();
    drive_req(TYPE_I, 32'd0, 32'h0000_0013);
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      @(negedge clk);
      exp = ((k * 3) << 20) | 32'h13;
      n_tests++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_valid[%0d]: got %b want 1", k, bus.out_valid); end
      n_tests++; if (bus.out_instr !== exp) begin n_fail++; $display("FAIL b2b_instr[%0d]: got %h want %h", k, bus.out_instr, exp); end
      n_tests++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_in_ready[%0d]: got %b want 1", k, bus.in_ready); end
      if (k < 3) drive_req(TYPE_I, (k + 1) * 3, 32'h0000_0013);
      else bus.in_valid = 1'b0;
    end
  endtask

  task automatic test_reset_pend();
    settle_empty();
    bus.out_ready = 1'b0;
    drive_req(TYPE_LI, 32'h1234_5678, 32'h0000_0280);
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    n_tests++; if (bus.out_instr !== 32'h1234_52B7) begin n_fail++; $display("FAIL rp_lui: got %h want 123452b7", bus.out_instr); end
    n_tests++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL rp_in_ready: got %b want 0", bus.in_ready); end
    #2 rst_n = 1'b0;
    #1;
    n_tests++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL rp_async_valid: got %b want 0", bus.out_valid); end
    n_tests++; if (bus.out_instr !== 32'h0) begin n_fail++; $display("FAIL rp_async_instr: got %h want 00000000", bus.out_instr); end
    @(negedge clk);
    rst_n         = 1'b1;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_tests++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL rp_no_addi[%0d]: valid %b instr %h want valid 0", k, bus.out_valid, bus.out_instr); end
    end
    n_tests++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL rp_in_ready_after: got %b want 1", bus.in_ready); end
  endtask

  initial begin
    test_reset();
    test_encode();
    test_li();
    test_backpressure();
    test_back_to_back();
    test_reset_pend();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
